// File: rtl/tdm_demux4.sv
// tdm_demux4: four-slot TDM demultiplexer with frame-sync hunt/lock and error counting
module tdm_demux4 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             fsync,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic             frame_valid,
  output logic [1:0]       slot,
  output logic             locked,
  output logic             sync_err,
  output logic [7:0]       err_count
);
  typedef enum logic {HUNT, LOCKED} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] stg0, stg1, stg2;
  logic misplaced;
  assign misplaced = state == LOCKED && fsync && slot != 2'd0;
  assign locked = state == LOCKED;
  // state register; lock is only lost through reset
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= HUNT;
    else state <= state_nx;
  // first fsync-qualified beat acquires lock
  always_comb state_nx = (state == HUNT && din_valid && fsync) ? LOCKED : state;
  // slot tracking, staging, frame delivery and sync error accounting
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      slot <= 2'd0;
      stg0 <= '0;
      stg1 <= '0;
      stg2 <= '0;
      out0 <= '0;
      out1 <= '0;
      out2 <= '0;
      out3 <= '0;
      frame_valid <= 1'b0;
      sync_err <= 1'b0;
      err_count <= 8'd0;
    end else begin
      frame_valid <= 1'b0;
      sync_err <= 1'b0;
      if (din_valid) begin
        if (state == HUNT) begin
          if (fsync) begin
            stg0 <= din;
            slot <= 2'd1;
          end
        end else if (misplaced) begin
          stg0 <= din;
          slot <= 2'd1;
          sync_err <= 1'b1;
          if (err_count != 8'hff) err_count <= err_count + 8'd1;
        end else begin
          case (slot)
            2'd0: stg0 <= din;
            2'd1: stg1 <= din;
            2'd2: stg2 <= din;
            default: begin
              out0 <= stg0;
              out1 <= stg1;
              out2 <= stg2;
              out3 <= din;
              frame_valid <= 1'b1;
            end
          endcase
          slot <= slot + 2'd1;
        end
      end
    end
endmodule

// File: tb/tb_tdm_demux4.sv
// tb_tdm_demux4: directed and randomized checks of tdm_demux4 against a frame-queue model
module tb_tdm_demux4;
  logic clk = 0, rst = 1, din_valid = 0, fsync = 0;
  logic [3:0] din = 0;
  logic [3:0] out0, out1, out2, out3;
  logic frame_valid, locked, sync_err;
  logic [1:0] slot;
  logic [7:0] err_count;
  int errors = 0, checks = 0, fv_seen = 0, se_seen = 0;
  bit m_locked, m_fv, m_se;
  int m_err;
  logic [3:0] q[$];
  logic [3:0] m_out[4];

  tdm_demux4 #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .fsync(fsync),
    .out0(out0), .out1(out1), .out2(out2), .out3(out3),
    .frame_valid(frame_valid), .slot(slot), .locked(locked),
    .sync_err(sync_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("out0", out0, m_out[0]);
    check("out1", out1, m_out[1]);
    check("out2", out2, m_out[2]);
    check("out3", out3, m_out[3]);
    check("frame_valid", frame_valid, m_fv);
    check("slot", slot, q.size());
    check("locked", locked, m_locked);
    check("sync_err", sync_err, m_se);
    check("err_count", err_count, m_err);
  endtask

  task automatic model_reset();
    m_locked = 0;
    q.delete();
    for (int i = 0; i < 4; i++) m_out[i] = 0;
    m_fv = 0;
    m_se = 0;
    m_err = 0;
  endtask

  task automatic cyc(input logic v, input logic f, input logic [3:0] d);
    din_valid = v;
    fsync = f;
    din = d;
    @(posedge clk);
    m_fv = 0;
    m_se = 0;
    if (v) begin
      if (!m_locked) begin
        if (f) begin
          q = {d};
          m_locked = 1;
        end
      end else if (f && q.size() != 0) begin
        q = {d};
        m_se = 1;
        if (m_err < 255) m_err++;
      end else begin
        q.push_back(d);
        if (q.size() == 4) begin
          for (int i = 0; i < 4; i++) m_out[i] = q[i];
          m_fv = 1;
          q.delete();
        end
      end
    end
    #1;
    check_all();
    if (frame_valid) fv_seen++;
    if (sync_err) se_seen++;
  endtask

  task automatic do_reset();
    din_valid = 0;
    fsync = 0;
    rst = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst = 0;
  endtask

  initial begin
    model_reset();
    do_reset();
    cyc(1, 1, 4'hA); cyc(1, 0, 4'hB); cyc(1, 0, 4'hC);
    fv_seen = 0;
    cyc(1, 0, 4'hD);
    check("abcd", {out0, out1, out2, out3}, 16'hABCD);
    cyc(0, 0, 4'h0);
    check("abcd_fv_once", fv_seen, 1);
    do_reset();
    cyc(1, 0, 4'h5); cyc(1, 0, 4'h6); cyc(1, 0, 4'h7);
    check("hunt_outs", {out0, out1, out2, out3, 2'b0, slot, 3'b0, locked}, 0);
    cyc(1, 1, 4'h1); cyc(1, 0, 4'h1); cyc(1, 0, 4'h1); cyc(1, 0, 4'h1);
    se_seen = 0;
    cyc(1, 1, 4'h1); cyc(1, 0, 4'h2); cyc(1, 1, 4'h9);
    cyc(1, 0, 4'h8); cyc(1, 0, 4'h7); cyc(1, 0, 4'h6);
    check("resync_outs", {out0, out1, out2, out3}, 16'h9876);
    check("resync_err_once", se_seen, 1);
    check("resync_cnt", err_count, 1);
    fv_seen = 0;
    for (int b = 1; b <= 4; b++) begin
      cyc(1, b == 1, b[3:0]);
      if (b < 4) repeat (3) cyc(0, 1, 4'hF);
    end
    check("gap_outs", {out0, out1, out2, out3}, 16'h1234);
    check("gap_fv", fv_seen, 1);
    fv_seen = 0;
    se_seen = 0;
    cyc(1, 1, 4'h3); cyc(1, 0, 4'h4); cyc(1, 0, 4'h5); cyc(1, 0, 4'h6);
    cyc(1, 0, 4'hC); cyc(1, 0, 4'hD); cyc(1, 0, 4'hE); cyc(1, 0, 4'hF);
    check("flywheel_outs", {out0, out1, out2, out3}, 16'hCDEF);
    check("flywheel_fv", fv_seen, 2);
    check("flywheel_no_err", se_seen, 0);
    for (int i = 0; i < 300; i++) begin
      cyc(1, 0, 4'h0);
      cyc(1, 1, i[3:0]);
    end
    check("err_sat", err_count, 255);
    cyc(1, 0, 4'h1);
    #2 rst = 1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1 rst = 0;
    cyc(1, 0, 4'h2);
    check("post_reset_hunt", locked, 0);
    for (int i = 0; i < 2000; i++)
      cyc(($urandom % 4) != 0, ($urandom % 6) == 0, 4'($urandom));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tdm_demux4.md
TDM_DEMUX4 -- requirements
Module: tdm_demux4

Interface
REQ-001 Parameter: WIDTH, default 1, lane data width in bits.
REQ-002 Port: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: din  input  WIDTH  time-multiplexed data beat.
REQ-005 Port: din_valid  input  1  din carries a beat this cycle.
REQ-006 Port: fsync  input  1  frame sync, qualified by din_valid; marks the beat as slot 0.
REQ-007 Port: out0, out1, out2, out3  output  WIDTH each  registered lane outputs, slots 0..3 of the last complete frame.
REQ-008 Port: frame_valid  output  1  one-cycle pulse, new frame loaded into out0..out3.
REQ-009 Port: slot  output  2  slot index the next accepted beat is stored to.
REQ-010 Port: locked  output  1  high in state LOCKED.
REQ-011 Port: sync_err  output  1  one-cycle pulse on a misplaced fsync.
REQ-012 Port: err_count  output  8  saturating count of sync_err events.

Function
REQ-013 Beat accepted: din_valid=1 on a rising edge; din and fsync are ignored when din_valid=0.
REQ-014 Two states: HUNT and LOCKED; reset enters HUNT.
REQ-015 HUNT: beats with fsync=0 are discarded; slot held at 0.
REQ-016 HUNT, beat with fsync=1: din stored to staging slot 0; slot becomes 1; state becomes LOCKED.
REQ-017 LOCKED, beat with fsync=0: din stored to staging[slot]; slot increments modulo 4.
REQ-018 LOCKED, beat at slot 3: staging 0..2 and current din load into out0..out3 on the same edge; frame_valid=1 for the following cycle only; slot wraps to 0.
REQ-019 LOCKED, fsync=1 at slot 0: normal slot-0 beat, no error.
REQ-020 LOCKED, fsync absent at slot 0: beat accepted as slot 0 (flywheel), no error.
REQ-021 LOCKED, fsync=1 at slot 1..3: partial frame discarded, out0..out3 unchanged, no frame_valid; beat stored as slot 0; slot becomes 1; sync_err=1 for one cycle; err_count increments.
REQ-022 err_count saturates at 255; no wrap.
REQ-023 Latency: slot-3 beat sampled at edge N -> outputs and frame_valid visible after edge N; one cycle.
REQ-024 out0..out3 hold their value until the next complete frame; partial frames never reach outputs.
REQ-025 din_valid gaps of any length within a frame are permitted; slot and staging hold.
REQ-026 locked never deasserts except on reset.

Reset
REQ-027 rst=1 forces immediately, regardless of clk: state HUNT; slot=0; out0..out3=0; staging=0; frame_valid=0; sync_err=0; locked=0; err_count=0.
REQ-028 Reset asserted mid-frame discards the partial frame; first beat after release requires fsync=1.
REQ-029 Reset deassertion takes effect at the first rising edge with rst=0.

Verification (WIDTH=4)
REQ-030 Reset, then beats A,B,C,D with fsync on A -> out0..3=A,B,C,D one cycle after the D edge; frame_valid pulses once; locked=1.
REQ-031 Beats 5,6,7 without fsync after reset -> no capture; slot=0; locked=0; outputs stay 0.
REQ-032 Locked; beats 1,2, then fsync beat 9, then 8,7,6 -> sync_err once; err_count=1; outputs 9,8,7,6; frame 1,2 never output.
REQ-033 Locked; frame 1,2,3,4 with din_valid low 3 cycles between each beat -> outputs 1,2,3,4; single frame_valid.
REQ-034 Two consecutive frames, second without fsync -> both frames delivered; two frame_valid pulses; no sync_err.
REQ-035 300 misplaced fsync events -> err_count=255; async rst mid-frame -> all outputs 0 before the next clk edge.
